pad_in_filter: RTL and testbench

PAD_IN_FILTER -- requirements
Module: pad_in_filter

---
 rtl/pad_in_filter.sv | 102 ++++++++++
 tb/tb_pad_in_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_in_filter.sv
// Pad input conditioning: 2-flop synchronizer, per-pad debounce filter, edge pulses.
// Optional sticky edge status and interrupt enabled by macro PAD_IN_FILTER_STATUS_EN.
module pad_in_filter #(
  parameter int unsigned NPads = 64,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NPads-1:0] pad_in_i,
  input  logic [NPads-1:0] filter_en_i,
  input  logic [CntW-1:0]  filter_thresh_i,
  input  logic [NPads-1:0] rise_en_i,
  input  logic [NPads-1:0] fall_en_i,
  input  logic [NPads-1:0] clr_rise_i,
  input  logic [NPads-1:0] clr_fall_i,
  output logic [NPads-1:0] filt_o,
  output logic [NPads-1:0] rise_o,
  output logic [NPads-1:0] fall_o,
  output logic [NPads-1:0] status_rise_o,
  output logic [NPads-1:0] status_fall_o,
  output logic             irq_o
);

  logic [NPads-1:0] s1_q;
  logic [NPads-1:0] s2_q;
  logic [NPads-1:0] filt_q;
  logic [NPads-1:0] filt_d;
  logic [NPads-1:0] filt_dly_q;
  logic [CntW-1:0]  cnt_q [NPads];
  logic [CntW-1:0]  cnt_d [NPads];

  // Synchronizer, filter state and one-cycle delayed filter value
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      for (int i = 0; i < int'(NPads); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= pad_in_i;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      for (int i = 0; i < int'(NPads); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Debounce: commit once the synchronized value has differed for thresh+1 cycles.
  // The >= compare bounds cnt by the threshold, so it cannot wrap.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < int'(NPads); i++) begin
      cnt_d[i] = '0;
      if (!filter_en_i[i]) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= filter_thresh_i) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_dly_q;
  assign fall_o = ~filt_q & filt_dly_q;

`ifdef PAD_IN_FILTER_STATUS_EN
  logic [NPads-1:0] st_rise_q;
  logic [NPads-1:0] st_fall_q;

  // Sticky status; a new edge in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_rise_q <= '0;
      st_fall_q <= '0;
    end else begin
      st_rise_q <= (st_rise_q & ~clr_rise_i) | (rise_o & rise_en_i);
      st_fall_q <= (st_fall_q & ~clr_fall_i) | (fall_o & fall_en_i);
    end
  end

  assign status_rise_o = st_rise_q;
  assign status_fall_o = st_fall_q;
  assign irq_o         = |{st_rise_q, st_fall_q};
`else
  logic unused_status_inputs;

  assign unused_status_inputs = ^{rise_en_i, fall_en_i, clr_rise_i, clr_fall_i};
  assign status_rise_o        = '0;
  assign status_fall_o        = '0;
  assign irq_o                = 1'b0;
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural run-length model.
module tb_pad_in_filter;
  localparam int unsigned NPads = 8;
  localparam int unsigned CntW  = 8;
`ifdef PAD_IN_FILTER_STATUS_EN
  localparam bit StEn = 1'b1;
`else
  localparam bit StEn = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [NPads-1:0] pad_in_i = '0;
  logic [NPads-1:0] filter_en_i = '0;
  logic [CntW-1:0]  filter_thresh_i = '0;
  logic [NPads-1:0] rise_en_i = '0;
  logic [NPads-1:0] fall_en_i = '0;
  logic [NPads-1:0] clr_rise_i = '0;
  logic [NPads-1:0] clr_fall_i = '0;
  logic [NPads-1:0] filt_o;
  logic [NPads-1:0] rise_o;
  logic [NPads-1:0] fall_o;
  logic [NPads-1:0] status_rise_o;
  logic [NPads-1:0] status_fall_o;
  logic             irq_o;

  pad_in_filter #(.NPads(NPads), .CntW(CntW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pad_in_i(pad_in_i), .filter_en_i(filter_en_i),
    .filter_thresh_i(filter_thresh_i), .rise_en_i(rise_en_i), .fall_en_i(fall_en_i),
    .clr_rise_i(clr_rise_i), .clr_fall_i(clr_fall_i), .filt_o(filt_o), .rise_o(rise_o),
    .fall_o(fall_o), .status_rise_o(status_rise_o), .status_fall_o(status_fall_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Model: pipeline of sampled pad values plus a run length of disagreeing cycles per pad
  bit [NPads-1:0] m_s1, m_s2, m_filt, m_prev, m_sr, m_sf;
  bit [NPads-1:0] m_rnow, m_fnow;
  int             m_run [NPads];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_prev = '0; m_sr = '0; m_sf = '0;
      for (int i = 0; i < int'(NPads); i++) m_run[i] = 0;
    end else begin
      m_rnow = m_filt & ~m_prev;
      m_fnow = ~m_filt & m_prev;
      m_sr = (m_sr & ~clr_rise_i) | (m_rnow & rise_en_i);
      m_sf = (m_sf & ~clr_fall_i) | (m_fnow & fall_en_i);
      m_prev = m_filt;
      for (int i = 0; i < int'(NPads); i++) begin
        if (!filter_en_i[i]) begin
          m_filt[i] = m_s2[i];
          m_run[i] = 0;
        end else if (m_s2[i] == m_filt[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] > int'(filter_thresh_i)) begin
            m_filt[i] = m_s2[i];
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = pad_in_i;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk_i) begin
    if (cmp_on) begin
      chk("filt_o", 64'(filt_o), 64'(m_filt));
      chk("rise_o", 64'(rise_o), 64'(m_filt & ~m_prev));
      chk("fall_o", 64'(fall_o), 64'(~m_filt & m_prev));
      chk("status_rise_o", 64'(status_rise_o), StEn ? 64'(m_sr) : 64'd0);
      chk("status_fall_o", 64'(status_fall_o), StEn ? 64'(m_sf) : 64'd0);
      chk("irq_o", 64'(irq_o), StEn ? 64'(|{m_sr, m_sf}) : 64'd0);
    end
  end

  initial begin
    logic [NPads-1:0] mask;
    tick;
    cmp_on = 1'b1;
    tick; tick;
    chk("reset_filt", 64'(filt_o), 64'd0);
    chk("reset_rise", 64'(rise_o), 64'd0);
    chk("reset_status", 64'({status_rise_o, status_fall_o}), 64'd0);
    chk("reset_irq", 64'(irq_o), 64'd0);
    rst_ni = 1'b1;
    tick; tick;

    // Unfiltered latency: change seen on the third edge
    pad_in_i[0] = 1'b1;
    tick; tick;
    chk("t034_filt_e2", 64'(filt_o[0]), 64'd0);
    tick;
    chk("t034_filt_e3", 64'(filt_o[0]), 64'd1);
    chk("t034_rise_e3", 64'(rise_o[0]), 64'd1);
    tick;
    chk("t034_rise_e4", 64'(rise_o[0]), 64'd0);

    // Threshold 4: 4-cycle pulse rejected, 5-cycle hold accepted at edge 7
    filter_en_i[1] = 1'b1;
    filter_thresh_i = 8'd4;
    pad_in_i[1] = 1'b1;
    repeat (4) tick;
    pad_in_i[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      chk("t035_short", 64'(filt_o[1]), 64'd0);
    end
    pad_in_i[1] = 1'b1;
    repeat (6) tick;
    chk("t035_e6", 64'(filt_o[1]), 64'd0);
    tick;
    chk("t035_e7_filt", 64'(filt_o[1]), 64'd1);
    chk("t035_e7_rise", 64'(rise_o[1]), 64'd1);

    // Sticky rise status and clear
    rise_en_i[2] = 1'b1;
    pad_in_i[2] = 1'b1;
    repeat (3) tick;
    chk("t036_rise", 64'(rise_o[2]), 64'd1);
    tick;
    chk("t036_status", 64'(status_rise_o[2]), 64'(StEn));
    chk("t036_irq", 64'(irq_o), 64'(StEn));
    clr_rise_i[2] = 1'b1;
    tick;
    clr_rise_i[2] = 1'b0;
    chk("t036_cleared", 64'(status_rise_o[2]), 64'd0);
    chk("t036_irq_cleared", 64'(irq_o), 64'd0);

    // Set wins over a simultaneous clear
    fall_en_i[3] = 1'b1;
    pad_in_i[3] = 1'b1;
    repeat (4) tick;
    pad_in_i[3] = 1'b0;
    repeat (3) tick;
    chk("t037_fall", 64'(fall_o[3]), 64'd1);
    clr_fall_i[3] = 1'b1;
    tick;
    clr_fall_i[3] = 1'b0;
    chk("t037_status", 64'(status_fall_o[3]), 64'(StEn));
    chk("t037_irq", 64'(irq_o), 64'(StEn));

    // Threshold lowered mid-count commits on the next differing cycle
    filter_en_i[4] = 1'b1;
    filter_thresh_i = 8'd200;
    pad_in_i[4] = 1'b1;
    repeat (52) tick;
    chk("t038_pre", 64'(filt_o[4]), 64'd0);
    filter_thresh_i = 8'd10;
    tick;
    chk("t038_commit", 64'(filt_o[4]), 64'd1);
    chk("t038_rise", 64'(rise_o[4]), 64'd1);

    // Reset mid-debounce discards the count; high pads rise again after release
    filter_en_i[5] = 1'b1;
    filter_thresh_i = 8'd20;
    pad_in_i[5] = 1'b1;
    repeat (10) tick;
    rst_ni = 1'b0;
    pad_in_i[5] = 1'b0;
    tick;
    chk("t038_rst_filt", 64'(filt_o), 64'd0);
    chk("t038_rst_edges", 64'({rise_o, fall_o}), 64'd0);
    chk("t038_rst_status", 64'({status_rise_o, status_fall_o, irq_o}), 64'd0);
    rst_ni = 1'b1;
    repeat (2) tick;
    chk("t030_rise_e2", 64'(rise_o[0]), 64'd0);
    tick;
    chk("t030_rise_e3", 64'(rise_o[0]), 64'd1);
    for (int k = 0; k < 27; k++) begin
      tick;
      chk("t038_no_pulse", 64'(rise_o[5]), 64'd0);
    end

    // Randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      tick;
      mask = NPads'($urandom & $urandom & $urandom);
      pad_in_i = pad_in_i ^ mask;
      if ($urandom_range(49) == 0) filter_en_i = NPads'($urandom);
      if ($urandom_range(39) == 0) filter_thresh_i = CntW'($urandom_range(6));
      if ($urandom_range(29) == 0) rise_en_i = NPads'($urandom);
      if ($urandom_range(29) == 0) fall_en_i = NPads'($urandom);
      clr_rise_i = NPads'($urandom & $urandom);
      clr_fall_i = NPads'($urandom & $urandom);
      rst_ni = ($urandom_range(499) != 0);
    end
    rst_ni = 1'b1;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
